// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry pc/instr holding register that catches a response while decode is stalled.
module fetch_skid_buffer #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               load,
    input  logic               drain,
    input  logic               clear,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               buf_valid,
    output logic [PC_W-1:0]    buf_pc,
    output logic [INSTR_W-1:0] buf_instr
);

    logic               valid_q;
    logic [PC_W-1:0]    pc_q;
    logic [INSTR_W-1:0] instr_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            if (clear) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= 1'b1;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            if (load && !clear) begin
                pc_q    <= load_pc;
                instr_q <= load_instr;
            end
        end
    end

    assign buf_valid = valid_q;
    assign buf_pc    = pc_q;
    assign buf_instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem request, skid buffer and IF/ID slot.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = 64,
    parameter int unsigned     INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req_valid,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_instr,
    output logic               if_id_valid,
    output logic [PC_W-1:0]    if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [6:0]         if_id_opcode
);

    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               slot_valid_q, slot_valid_d;
    logic [PC_W-1:0]    slot_pc_q, slot_pc_d;
    logic [INSTR_W-1:0] slot_instr_q, slot_instr_d;

    logic               buf_valid;
    logic [PC_W-1:0]    buf_pc;
    logic [INSTR_W-1:0] buf_instr;
    logic               buf_load, buf_drain;

    logic               rsp_take, slot_free, req_fire;
    logic [PC_W-1:0]    redirect_target;

    assign redirect_target = {redirect_pc[PC_W-1:2], 2'b00};
    assign rsp_take        = (state_q == WAIT) && imem_rsp_valid;
    assign slot_free       = !slot_valid_q || !stall;

    // Gated by arst_n so no request leaks out while reset is held.
    assign imem_req_valid = arst_n && (state_q == FETCH) && !buf_valid && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        buf_load     = 1'b0;
        buf_drain    = 1'b0;

        if (redirect_valid) begin
            pc_d         = redirect_target;
            slot_valid_d = 1'b0;
            slot_instr_d = NOP;
            // An in-flight response must still be swallowed before fetching the target.
            if ((state_q == WAIT || state_q == DISCARD) && !imem_rsp_valid) begin
                state_d = DISCARD;
            end else begin
                state_d = FETCH;
            end
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (req_fire) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        pc_d    = pc_q + PC_W'(PC_INC);
                        state_d = FETCH;
                    end
                end
                DISCARD: begin
                    if (imem_rsp_valid) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase

            if (!stall) begin
                if (buf_valid) begin
                    slot_valid_d = 1'b1;
                    slot_pc_d    = buf_pc;
                    slot_instr_d = buf_instr;
                    buf_drain    = 1'b1;
                end else if (rsp_take) begin
                    slot_valid_d = 1'b1;
                    slot_pc_d    = pc_q;
                    slot_instr_d = imem_rsp_instr;
                end else begin
                    slot_valid_d = 1'b0;
                    slot_instr_d = NOP;
                end
            end else if (rsp_take && !slot_valid_q) begin
                slot_valid_d = 1'b1;
                slot_pc_d    = pc_q;
                slot_instr_d = imem_rsp_instr;
            end

            buf_load = rsp_take && !slot_free;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= '0;
            slot_instr_q <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
        end
    end

    fetch_skid_buffer #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .arst_n     (arst_n),
        .load       (buf_load),
        .drain      (buf_drain),
        .clear      (redirect_valid),
        .load_pc    (pc_q),
        .load_instr (imem_rsp_instr),
        .buf_valid  (buf_valid),
        .buf_pc     (buf_pc),
        .buf_instr  (buf_instr)
    );

    assign if_id_valid  = slot_valid_q;
    assign if_id_pc     = slot_pc_q;
    assign if_id_instr  = slot_instr_q;
    assign if_id_opcode = slot_instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level model of delivered instructions.
module tb_fetch_unit;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam logic [31:0] NOP      = 32'h00000013;

    logic               clk = 1'b0;
    logic               arst_n;
    logic               stall;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               imem_req_valid;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_instr;
    logic               if_id_valid;
    logic [PC_W-1:0]    if_id_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [6:0]         if_id_opcode;

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_instr (imem_rsp_instr),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_opcode   (if_id_opcode)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: instructions owed to decode, in order, plus the memory's one outstanding request.
    logic [63:0] owed_q[$];
    logic [63:0] next_pc;
    logic [63:0] out_addr;
    bit          busy, stale, reset_seen, pc_zero;
    int          lat_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        logic [31:0] h;
        h = addr[31:0] ^ addr[63:32] ^ 32'h0bad_f00d;
        return h * 32'h9e37_79b1 + 32'h0123_4567;
    endfunction

    function automatic logic [63:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return 64'h100 + 64'($urandom_range(0, 3));
            1:       return 64'hffff_ffff_ffff_fff0 | 64'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic step(input int p_stall, input int p_redir, input int p_ready,
                        input int max_lat, input bit rst);
        bit          s_req, s_ready, s_rsp, s_rv, s_stall, s_rst, live, consume, exp_req;
        logic [63:0] s_rp, exp_instr;

        @(negedge clk);
        arst_n         = !rst;
        stall          = ($urandom_range(0, 99) < p_stall);
        redirect_valid = !rst && ($urandom_range(0, 99) < p_redir);
        redirect_pc    = pick_target();
        imem_req_ready = ($urandom_range(0, 99) < p_ready);
        imem_rsp_valid = busy && (lat_cnt == 1);
        imem_rsp_instr = imem_rsp_valid ? mem_word(out_addr) : $urandom;
        #1;

        if (reset_seen) begin
            exp_req = !rst && !busy && (owed_q.size() < 2) && !redirect_valid;
            check("req_valid", 64'(imem_req_valid), 64'(exp_req));
            if (exp_req) check("req_addr", imem_req_addr, next_pc);
            check("if_id_valid", 64'(if_id_valid), 64'(owed_q.size() > 0));
            exp_instr = (owed_q.size() > 0) ? 64'(mem_word(owed_q[0])) : 64'(NOP);
            check("if_id_instr", 64'(if_id_instr), exp_instr);
            check("if_id_opcode", 64'(if_id_opcode), 64'(exp_instr[6:0]));
            if (owed_q.size() > 0) check("if_id_pc", if_id_pc, owed_q[0]);
            else if (pc_zero) check("if_id_pc_rst", if_id_pc, 64'h0);
        end

        s_req   = imem_req_valid;
        s_ready = imem_req_ready;
        s_rsp   = imem_rsp_valid;
        s_rv    = redirect_valid;
        s_rp    = redirect_pc;
        s_stall = stall;
        s_rst   = rst;

        @(posedge clk);
        if (s_rst) begin
            owed_q.delete();
            busy       = 1'b0;
            stale      = 1'b0;
            next_pc    = RESET_PC;
            reset_seen = 1'b1;
            pc_zero    = 1'b1;
        end else begin
            consume = (owed_q.size() > 0) && !s_stall;
            live    = 1'b0;
            if (s_rsp) begin
                busy  = 1'b0;
                live  = !stale && !s_rv;
                stale = 1'b0;
            end else if (busy) begin
                lat_cnt--;
            end
            if (s_rv) begin
                owed_q.delete();
                next_pc = s_rp & ~64'h3;
                if (busy) stale = 1'b1;
            end else begin
                if (consume) void'(owed_q.pop_front());
                if (live) begin
                    owed_q.push_back(out_addr);
                    pc_zero = 1'b0;
                end
                if (s_req && s_ready) begin
                    busy     = 1'b1;
                    stale    = 1'b0;
                    out_addr = next_pc;
                    lat_cnt  = $urandom_range(1, max_lat);
                    next_pc  = next_pc + 64'd4;
                end
            end
        end
    endtask

    initial begin
        arst_n         = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_instr = '0;
        busy           = 1'b0;
        stale          = 1'b0;
        reset_seen     = 1'b0;
        pc_zero        = 1'b1;
        lat_cnt        = 0;
        next_pc        = RESET_PC;
        out_addr       = '0;

        repeat (3) step(0, 0, 100, 1, 1'b1);
        // Straight-line fetch, L=1: pc 0, 4, 8 ... every two cycles.
        repeat (20) step(0, 0, 100, 1, 1'b0);
        // Heavy stalling fills the skid buffer.
        repeat (200) step(60, 0, 70, 3, 1'b0);
        // Redirects landing in every state, including alongside responses.
        repeat (400) step(30, 10, 70, 4, 1'b0);

        // Reset while a response is pending.
        for (int i = 0; i < 50 && !busy; i++) step(0, 0, 100, 4, 1'b0);
        check("reset_mid_wait_reached", 64'(busy), 64'd1);
        repeat (2) step(0, 0, 100, 4, 1'b1);
        repeat (20) step(0, 0, 100, 1, 1'b0);

        repeat (2000) step(25, 5, 60, 4, 1'b0);
        repeat (40) step(0, 0, 100, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
